// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one input bit per cycle).
// Signed inputs are converted by magnitude with a separate sign flag.
module bin2bcd_seq #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIGITS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             sign,
    output logic [3:0]       bcd [DIGITS-1:0],
    output logic             ovf
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic              neg_q, neg_d;
    logic [BcdW-1:0]   work_q, work_d;
    logic              carry_q, carry_d;
    logic              done_q, done_d;
    logic              sign_q, sign_d;
    logic              ovf_q, ovf_d;
    logic [BcdW-1:0]   res_q, res_d;

    logic [BcdW-1:0]   adj;
    logic [BcdW-1:0]   shifted;
    logic              carry_next;
    logic              in_neg;
    logic [WIDTH-1:0]  in_mag;

    // Magnitude of the operand; negating the most negative value wraps onto
    // 2^(WIDTH-1), which is exactly the wanted unsigned magnitude.
    always_comb begin
        in_neg = is_signed & value[WIDTH-1];
        in_mag = in_neg ? -value : value;
    end

    // Add-3 correction on every digit >= 5, then shift in the next magnitude bit.
    always_comb begin
        adj = work_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        shifted    = {adj[BcdW-2:0], mag_q[WIDTH-1]};
        carry_next = carry_q | adj[BcdW-1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        work_d  = work_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        res_d   = res_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mag_d   = in_mag;
                    neg_d   = in_neg;
                    work_d  = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = StShift;
                end
            end
            StShift: begin
                work_d  = shifted;
                mag_d   = mag_q << 1;
                carry_d = carry_next;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    ovf_d   = carry_next;
                    // A set neg flag implies a nonzero magnitude, so no negative zero.
                    sign_d  = neg_q;
                    res_d   = carry_next ? {BcdW{1'b1}} : shifted;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            work_q  <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        busy = (state_q == StShift);
        done = done_q;
        sign = sign_q;
        ovf  = ovf_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            bcd[i] = res_q[4*i +: 4];
        end
    end

endmodule
